// File: rtl/ir_pkg.sv
// Shared types and constants for the IR scan sequencer: FSM state encoding,
// channel count/width and the default A2D result width.
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CONV,
    WAIT,
    DONE
  } ir_state_t;

  localparam int IR_NUM_CH = 8;
  localparam int IR_CH_W   = 3;
  localparam int IR_DW_DEF = 12;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ir_bank.sv
// Shadow/readout register bank: conversions land in shadow, a commit strobe
// copies the whole shadow into the readout bank seen through the sel mux.
module ir_bank
  import ir_pkg::*;
#(
  parameter int DW = IR_DW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IR_CH_W-1:0] wr_addr,
  input  logic [DW-1:0]      wr_data,
  input  logic               commit,
  input  logic [IR_CH_W-1:0] sel,
  output logic [DW-1:0]      rd_data
);

  logic [DW-1:0] bank_word [IR_NUM_CH];

  for (genvar gi = 0; gi < IR_NUM_CH; gi++) begin : g_entry
    logic [DW-1:0] shadow_reg;
    logic [DW-1:0] bank_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        shadow_reg <= '0;
        bank_reg   <= '0;
      end else begin
        if (wr_en && (wr_addr == IR_CH_W'(gi))) begin
          shadow_reg <= wr_data;
        end
        if (commit) begin
          bank_reg <= shadow_reg;
        end
      end
    end

    assign bank_word[gi] = bank_reg;
  end

  assign rd_data = bank_word[sel];

endmodule

// File: rtl/ir_sample_seq.sv
// Periodic IR scan sequencer: settle, eight A2D conversions, commit, IR_vld.
// Define IR_DBL_SAMPLE_EN to convert each channel twice and store the average.
module ir_sample_seq
  import ir_pkg::*;
#(
  parameter int PERIOD = 50000,
  parameter int SETTLE = 256,
  parameter int DW     = IR_DW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic               IR_en,
  output logic               strt_cnv,
  output logic [IR_CH_W-1:0] chnnl,
  input  logic               cnv_cmplt,
  input  logic [DW-1:0]      res,
  input  logic [IR_CH_W-1:0] sel,
  output logic [DW-1:0]      ir_rd,
  output logic               IR_vld,
  output logic               busy
);

  localparam int TW = cnt_w(PERIOD);
  localparam int SW = cnt_w(SETTLE);

  ir_state_t          state_reg, state_next;
  logic [TW-1:0]      timer_reg;
  logic [SW-1:0]      settle_reg;
  logic [IR_CH_W-1:0] ch_reg;
  logic               tc;
  logic               last_ch;
  logic               wr_en;
  logic               commit;
  logic [DW-1:0]      wr_data;

  assign tc      = (timer_reg == TW'(PERIOD - 1));
  assign last_ch = (ch_reg == IR_CH_W'(IR_NUM_CH - 1));

`ifdef IR_DBL_SAMPLE_EN
  logic [DW-1:0] first_reg;
  logic          second_reg;
  logic [DW:0]   pair_sum;

  // Average in DW+1 bits so the carry is kept, then drop the LSB (truncate).
  assign pair_sum = {1'b0, first_reg} + {1'b0, res};
  assign wr_data  = pair_sum[DW:1];
`else
  assign wr_data  = res;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      timer_reg  <= '0;
      settle_reg <= '0;
      ch_reg     <= '0;
`ifdef IR_DBL_SAMPLE_EN
      first_reg  <= '0;
      second_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      // Free-running in every state; terminal counts during a scan are dropped.
      timer_reg <= tc ? '0 : timer_reg + 1'b1;
      case (state_reg)
        IDLE: begin
          settle_reg <= '0;
          ch_reg     <= '0;
`ifdef IR_DBL_SAMPLE_EN
          second_reg <= 1'b0;
`endif
        end
        ir_pkg::SETTLE: begin
          settle_reg <= settle_reg + 1'b1;
        end
        WAIT: begin
          if (cnv_cmplt) begin
`ifdef IR_DBL_SAMPLE_EN
            if (!second_reg) begin
              first_reg  <= res;
              second_reg <= 1'b1;
            end else begin
              second_reg <= 1'b0;
              if (!last_ch) ch_reg <= ch_reg + 1'b1;
            end
`else
            if (!last_ch) ch_reg <= ch_reg + 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    IR_en      = 1'b0;
    strt_cnv   = 1'b0;
    chnnl      = '0;
    IR_vld     = 1'b0;
    busy       = (state_reg != IDLE);
    wr_en      = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (tc && en) state_next = ir_pkg::SETTLE;
      end
      ir_pkg::SETTLE: begin
        IR_en = 1'b1;
        if (settle_reg == SW'(SETTLE - 1)) state_next = CONV;
      end
      CONV: begin
        IR_en      = 1'b1;
        strt_cnv   = 1'b1;
        chnnl      = ch_reg;
        state_next = WAIT;
      end
      WAIT: begin
        IR_en = 1'b1;
        chnnl = ch_reg;
        if (cnv_cmplt) begin
`ifdef IR_DBL_SAMPLE_EN
          if (!second_reg) begin
            state_next = CONV;
          end else begin
            wr_en      = 1'b1;
            state_next = last_ch ? DONE : CONV;
          end
`else
          wr_en      = 1'b1;
          state_next = last_ch ? DONE : CONV;
`endif
        end
      end
      DONE: begin
        IR_vld     = 1'b1;
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  ir_bank #(
    .DW(DW)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(ch_reg),
    .wr_data(wr_data),
    .commit (commit),
    .sel    (sel),
    .rd_data(ir_rd)
  );

endmodule

// File: doc/ir_sample_seq.md
# ir_sample_seq

Periodic IR sensor scan sequencer and the producer side of the error-computation handshake. It drives the IR emitters and waits a settle time. It then runs eight A2D conversions over channels 0..7 and latches the results into a readout bank. When the bank is complete it pulses `IR_vld` and serves readings back by `sel` while the error-computation state machine walks channels 0..7.

## Interface
- `PERIOD`, default 50000: cycles between scan starts; legal range 32 or more.
- `SETTLE`, default 256: cycles `IR_en` is held before the first conversion; legal range 1 or more.
- `DW`, default 12: A2D result width.
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: synchronous, active-high reset.
- `en` input, 1 bit: allows new scans to start; sampled only in IDLE.
- `IR_en` output, 1 bit: IR emitter enable.
- `strt_cnv` output, 1 bit: one-cycle A2D start pulse.
- `chnnl` output, 3 bits: A2D channel, valid while a conversion is outstanding.
- `cnv_cmplt` input, 1 bit: A2D done pulse.
- `res` input, DW bits: A2D result, valid with `cnv_cmplt`.
- `sel` input, 3 bits: readout channel select from the error-computation block.
- `ir_rd` output, DW bits: `bank[sel]`, combinational.
- `IR_vld` output, 1 bit: one-cycle pulse, new bank committed.
- `busy` output, 1 bit: high in every state except IDLE.

## Operation
- Reset values: `IR_en`=0, `strt_cnv`=0, `chnnl`=0, `IR_vld`=0, `busy`=0. Both banks are cleared to 0, so `ir_rd`=0. Period timer=0, state=IDLE.
- States are IDLE, SETTLE, CONV, WAIT and DONE.
- IDLE: the period timer counts 0..PERIOD-1 and wraps, free-running even when `en`=0.
  - When the timer is at PERIOD-1 and `en`=1, go to SETTLE and clear the settle counter and channel counter `ch`.
- SETTLE: `IR_en`=1. The settle counter runs 0..SETTLE-1; at SETTLE-1, go to CONV.
- CONV (one cycle): `strt_cnv`=1, `chnnl`=`ch`, then go to WAIT.
- WAIT: `IR_en`=1 and `chnnl`=`ch` are held.
  - On `cnv_cmplt`, write `res` into `shadow[ch]`.
  - If `ch`=7, go to DONE; otherwise increment `ch` and go to CONV.
- DONE (one cycle): `IR_en`=0 and `IR_vld`=1. `shadow` is copied to `bank` in the same cycle, so the new values are visible on `ir_rd` from the next cycle. Then go to IDLE.
- `IR_en` is high in SETTLE, CONV and WAIT only.
- `cnv_cmplt` outside WAIT is ignored. The A2D minimum latency is 1, so `cnv_cmplt` coinciding with `strt_cnv` is never legal and is ignored.
- No timeout: WAIT holds indefinitely until `cnv_cmplt`.
- `en` falling mid-scan does not abort; the scan completes and `IR_vld` fires. No new scan starts while `en`=0.
- The period timer keeps running during a scan. A terminal count reached while `busy`=1 is dropped; scans never queue.
- `rst` mid-scan returns every output and both banks to reset values in the next cycle. No `IR_vld` is produced for the aborted scan.
- `bank` changes only in DONE. `ir_rd` is therefore stable for at least PERIOD-1 cycles after `IR_vld`, which covers the eight-cycle `sel` walk.

## Timing
- Let t0 be the IDLE cycle at terminal count with `en`=1, and let the A2D return `cnv_cmplt` L cycles after `strt_cnv`.
- `IR_en` rises at t0+1.
- The first `strt_cnv` is at t0+1+SETTLE.
- Each channel occupies L+1 cycles.
- `IR_vld` is at t0+1+SETTLE+8(L+1) (16(L+1) with double sampling).
- The next eligible start is t0+PERIOD if the scan finished before then.

## Configuration
- `IR_DBL_SAMPLE_EN` defined:
  - Each channel is converted twice (CONV/WAIT run twice per `ch`, same `chnnl`).
  - `shadow[ch]` = (first + second) >> 1, computed in DW+1 bits and truncated, with no rounding.
  - `IR_vld` latency doubles as shown above.
- `IR_DBL_SAMPLE_EN` undefined: one conversion per channel, stored raw.

## Structure
- Package `ir_pkg` holds:
  - the state enum `ir_state_t` (IDLE, SETTLE, CONV, WAIT, DONE);
  - `IR_NUM_CH`=8 and `IR_CH_W`=3;
  - the default `DW`.
- Sub-module `ir_bank` holds the shadow write port, the commit strobe, the output bank and the `sel` read mux, with synchronous clear on `rst`.

## Test plan
- Basic scan: PERIOD=64, SETTLE=4, L=3, `res`=0x100+ch → `IR_en` from t0+1, `IR_vld` at t0+37. Walking `sel` 0..7 afterwards reads 0x100..0x107.
- Bank stability: second scan with `res`=0xA00+ch → `ir_rd` holds the old values until the DONE cycle and shows the new values from the cycle after `IR_vld`.
- Enable gating: `en`=0 across a terminal count → no `IR_en`, `busy`=0. `en` dropped during WAIT of ch3 → scan completes and `IR_vld` fires once.
- Reset mid-scan: `rst` during WAIT of ch5 → next cycle all outputs 0 and `ir_rd`=0 for every `sel`; no `IR_vld`.
- Variable latency: L alternating 1 and 9, plus a spurious `cnv_cmplt` in IDLE → correct per-channel values, spurious pulse ignored.
- `IR_DBL_SAMPLE_EN`: samples 0x0FF then 0x100 for each channel → stored value 0x0FF, `IR_vld` at t0+1+SETTLE+16(L+1).
